// File: rtl/cmul_pipe.sv
// Pipelined complex multiplier for the FFT twiddle path.
// Three register stages: operand capture, partial products, sum/round/shift/saturate.
// The whole pipe advances together whenever the output register is free or being taken.
module cmul_pipe #(
  parameter int unsigned BFLY_W = 10,
  parameter int unsigned TW_W   = 9,
  parameter int unsigned OUT_W  = 10,
  parameter int unsigned SHIFT  = 8,
  parameter int unsigned ROUND  = 1,
  parameter int unsigned SAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     conj,
  input  logic signed [BFLY_W-1:0] bfly_re,
  input  logic signed [BFLY_W-1:0] bfly_im,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_re,
  output logic signed [OUT_W-1:0]  out_im,
  output logic                     out_ovf,
  input  logic                     ovf_clr,
  output logic                     ovf_sticky
);

  localparam int unsigned PW  = BFLY_W + TW_W;
  localparam int unsigned SW  = PW + 1;
  localparam int unsigned RW  = SW + 1;
  localparam int unsigned RSH = (SHIFT > 0) ? (SHIFT - 1) : 0;

  // Rounding bias only exists when there are bits to shift out.
  localparam logic signed [RW-1:0] RND_K =
    ((ROUND != 0) && (SHIFT > 0)) ? (RW'(1) << RSH) : RW'(0);
  localparam logic signed [RW-1:0] MAXV = (RW'(1) << (OUT_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic                     w_adv;
  logic                     r_v1, r_cj1, r_v2, r_cj2;
  logic signed [BFLY_W-1:0] r_bre, r_bim;
  logic signed [TW_W-1:0]   r_twr, r_twi;
  logic signed [PW-1:0]     r_prr, r_pii, r_pir, r_pri;
  logic signed [SW-1:0]     w_re_full, w_im_full;
  logic        [OUT_W:0]    w_sc_re, w_sc_im;

  // Round, shift and clamp/wrap one component; MSB of result is the overflow flag.
  function automatic logic [OUT_W:0] scale(input logic signed [SW-1:0] v);
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] shf;
    logic                 ovf;
    logic [OUT_W-1:0]     o;
    rnd = RW'(v) + RND_K;
    shf = rnd >>> SHIFT;
    ovf = (shf > MAXV) || (shf < MINV);
    if (ovf && (SAT != 0)) begin
      o = shf[RW-1] ? MINV[OUT_W-1:0] : MAXV[OUT_W-1:0];
    end else begin
      o = shf[OUT_W-1:0];
    end
    return {ovf, o};
  endfunction

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  // Full-precision sums; conj flips the sign of the twiddle imaginary part.
  assign w_re_full = r_cj2 ? (SW'(r_prr) + SW'(r_pii)) : (SW'(r_prr) - SW'(r_pii));
  assign w_im_full = r_cj2 ? (SW'(r_pir) - SW'(r_pri)) : (SW'(r_pir) + SW'(r_pri));
  assign w_sc_re   = scale(w_re_full);
  assign w_sc_im   = scale(w_im_full);

  // Stage 1: capture operands and conj flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_cj1 <= 1'b0;
      r_bre <= '0;
      r_bim <= '0;
      r_twr <= '0;
      r_twi <= '0;
    end else if (w_adv) begin
      r_v1  <= in_valid;
      r_cj1 <= conj;
      r_bre <= bfly_re;
      r_bim <= bfly_im;
      r_twr <= tw_re;
      r_twi <= tw_im;
    end
  end

  // Stage 2: four partial products at full width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2  <= 1'b0;
      r_cj2 <= 1'b0;
      r_prr <= '0;
      r_pii <= '0;
      r_pir <= '0;
      r_pri <= '0;
    end else if (w_adv) begin
      r_v2  <= r_v1;
      r_cj2 <= r_cj1;
      r_prr <= PW'(r_bre) * PW'(r_twr);
      r_pii <= PW'(r_bim) * PW'(r_twi);
      r_pir <= PW'(r_bim) * PW'(r_twr);
      r_pri <= PW'(r_bre) * PW'(r_twi);
    end
  end

  // Stage 3: scaled result register; overflow only flagged for real samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_ovf   <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_v2;
      out_re    <= w_sc_re[OUT_W-1:0];
      out_im    <= w_sc_im[OUT_W-1:0];
      out_ovf   <= r_v2 & (w_sc_re[OUT_W] | w_sc_im[OUT_W]);
    end
  end

  // Sticky overflow: a transferred overflowing sample beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid & out_ready & out_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmul_pipe.sv
// Bench for cmul_pipe: a default instance and a truncate/wrap instance share stimulus;
// outputs are scored against an arithmetic reference model through expectation queues.
module tb_cmul_pipe;

  localparam int OW = 10;
  localparam int SH = 8;

  typedef struct {
    logic signed [9:0] re;
    logic signed [9:0] im;
    logic              ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic conj = 1'b0;
  logic out_ready = 1'b0;
  logic ovf_clr = 1'b0;
  logic signed [9:0] bre = '0;
  logic signed [9:0] bim = '0;
  logic signed [8:0] twr = '0;
  logic signed [8:0] twi = '0;

  logic ir1, ov1, of1, st1, ir2, ov2, of2, st2;
  logic signed [9:0] ore1, oim1, ore2, oim2;

  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q2[$];
  bit   m_st1, m_st2;
  bit   s_acc, s_ir, s_ov1;
  logic signed [9:0] s_re1, s_im1, s_re2, s_im2;
  logic s_of1, s_of2, s_st1, s_st2;
  bit   p_hold;
  logic signed [9:0] p_re, p_im;
  int   n_out = 0;

  always #5 clk = ~clk;

  cmul_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .conj(conj),
    .bfly_re(bre), .bfly_im(bim), .tw_re(twr), .tw_im(twi),
    .out_valid(ov1), .out_ready(out_ready), .out_re(ore1), .out_im(oim1),
    .out_ovf(of1), .ovf_clr(ovf_clr), .ovf_sticky(st1)
  );

  cmul_pipe #(.ROUND(0), .SAT(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .conj(conj),
    .bfly_re(bre), .bfly_im(bim), .tw_re(twr), .tw_im(twi),
    .out_valid(ov2), .out_ready(out_ready), .out_re(ore2), .out_im(oim2),
    .out_ovf(of2), .ovf_clr(ovf_clr), .ovf_sticky(st2)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Complex product by plain integer arithmetic, then scale by 2^SH with floor.
  function automatic exp_t ref_mul(input int a, input int b, input int c, input int d,
                                   input bit cj, input bit rnd, input bit sat);
    longint rr, ii, ir, ri, re, im, hi, lo;
    exp_t e;
    rr = longint'(a) * c;
    ii = longint'(b) * d;
    ir = longint'(b) * c;
    ri = longint'(a) * d;
    re = cj ? rr + ii : rr - ii;
    im = cj ? ir - ri : ir + ri;
    if (rnd) begin
      re = re + (longint'(1) << (SH - 1));
      im = im + (longint'(1) << (SH - 1));
    end
    re = re >>> SH;
    im = im >>> SH;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -hi - 1;
    e.ovf = (re > hi) || (re < lo) || (im > hi) || (im < lo);
    if (sat) begin
      if (re > hi) re = hi;
      if (re < lo) re = lo;
      if (im > hi) im = hi;
      if (im < lo) im = lo;
    end
    e.re = re[9:0];
    e.im = im[9:0];
    return e;
  endfunction

  // One clock: sample and score at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e1, e2;
    @(negedge clk);
    s_acc = 1'b0;
    s_ir  = ir1;
    s_ov1 = ov1;
    s_re1 = ore1; s_im1 = oim1; s_of1 = of1; s_st1 = st1;
    s_re2 = ore2; s_im2 = oim2; s_of2 = of2; s_st2 = st2;
    if (!rst) begin
      chk("in_ready1", ir1, !ov1 || out_ready);
      chk("in_ready2", ir2, !ov2 || out_ready);
      chk("sticky1", st1, m_st1);
      chk("sticky2", st2, m_st2);
      if (p_hold) begin
        chk("hold_valid", ov1, 1);
        chk("hold_re", ore1, p_re);
        chk("hold_im", oim1, p_im);
      end
      s_acc = in_valid && ir1;
      if (s_acc) begin
        q1.push_back(ref_mul(bre, bim, twr, twi, conj, 1'b1, 1'b1));
        q2.push_back(ref_mul(bre, bim, twr, twi, conj, 1'b0, 1'b0));
      end
      if (ov1 && out_ready) begin
        chk("out_expected", q1.size() > 0, 1);
        chk("valid2", ov2, 1);
        if (q1.size() > 0 && q2.size() > 0) begin
          e1 = q1.pop_front();
          e2 = q2.pop_front();
          chk("re1", ore1, e1.re);
          chk("im1", oim1, e1.im);
          chk("ovf1", of1, e1.ovf);
          chk("re2", ore2, e2.re);
          chk("im2", oim2, e2.im);
          chk("ovf2", of2, e2.ovf);
          if (e1.ovf) m_st1 = 1'b1; else if (ovf_clr) m_st1 = 1'b0;
          if (e2.ovf) m_st2 = 1'b1; else if (ovf_clr) m_st2 = 1'b0;
        end
        n_out++;
      end else if (ovf_clr) begin
        m_st1 = 1'b0;
        m_st2 = 1'b0;
      end
      p_hold = ov1 && !out_ready;
      p_re   = ore1;
      p_im   = oim1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int a, input int b, input int c, input int d, input bit cj);
    bre  = 10'(a);
    bim  = 10'(b);
    twr  = 9'(c);
    twi  = 9'(d);
    conj = cj;
  endtask

  task automatic rand_in();
    bre  = ($urandom % 4 == 0) ? (($urandom % 2 == 1) ? 10'sh200 : 10'sh1ff) : 10'($urandom);
    bim  = ($urandom % 4 == 0) ? (($urandom % 2 == 1) ? 10'sh200 : 10'sh1ff) : 10'($urandom);
    twr  = ($urandom % 4 == 0) ? (($urandom % 2 == 1) ? 9'sh100 : 9'sh0ff) : 9'($urandom);
    twi  = ($urandom % 4 == 0) ? (($urandom % 2 == 1) ? 9'sh100 : 9'sh0ff) : 9'($urandom);
    conj = 1'($urandom);
  endtask

  // Single sample through an idle pipe; checks latency and both instances' results.
  task automatic send_one(input string tag, input int a, input int b, input int c, input int d,
                          input bit cj, input int r1, input int i1, input bit o1,
                          input int r2, input int i2, input bit o2);
    int lat;
    set_in(a, b, c, d, cj);
    in_valid = 1'b1;
    tick();
    chk({tag, "_acc"}, s_acc, 1);
    in_valid = 1'b0;
    for (lat = 1; lat <= 10; lat++) begin
      tick();
      if (s_ov1) break;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_re"}, s_re1, r1);
    chk({tag, "_im"}, s_im1, i1);
    chk({tag, "_ovf"}, s_of1, o1);
    chk({tag, "_re_w"}, s_re2, r2);
    chk({tag, "_im_w"}, s_im2, i2);
    chk({tag, "_ovf_w"}, s_of2, o2);
  endtask

  initial begin
    int k;
    int n0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ov1, 0);
    chk("rst_re", ore1, 0);
    chk("rst_im", oim1, 0);
    chk("rst_ovf", of1, 0);
    chk("rst_sticky", st1, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("in_ready_after_rst", ir1, 1);

    // Directed arithmetic cases
    send_one("basic",   100, -50, 128, 0,   1'b0,  50, -25, 1'b0,  50, -25, 1'b0);
    send_one("round",   3,   0,   128, 0,   1'b0,   2,   0, 1'b0,   1,   0, 1'b0);
    send_one("conj0",   100, 0,   0,   128, 1'b0,   0,  50, 1'b0,   0,  50, 1'b0);
    send_one("conj1",   100, 0,   0,   128, 1'b1,   0, -50, 1'b0,   0, -50, 1'b0);
    ovf_clr = 1'b1;
    send_one("sat",    -512, -512, -256, 255, 1'b0, 511, 2, 1'b1, -2, 2, 1'b1);
    tick();
    chk("sticky_set_wins", s_st1, 1);
    chk("sticky_set_wins_w", s_st2, 1);
    tick();
    chk("sticky_cleared", s_st1, 0);
    ovf_clr = 1'b0;

    // Backpressure: only three fit while the output is blocked
    out_ready = 1'b0;
    k = 0;
    for (int t = 0; t < 8; t++) begin
      in_valid = (k < 5);
      rand_in();
      tick();
      if (s_acc) k++;
    end
    chk("bp_accepted", k, 3);
    chk("bp_in_ready", s_ir, 0);
    out_ready = 1'b1;
    n0 = n_out;
    for (int t = 0; t < 20 && (k < 5 || q1.size() > 0); t++) begin
      in_valid = (k < 5);
      rand_in();
      tick();
      if (s_acc) k++;
    end
    in_valid = 1'b0;
    chk("bp_all_in", k, 5);
    chk("bp_out_count", n_out - n0, 5);
    chk("bp_queue_empty", q1.size(), 0);

    // Asynchronous reset with samples in flight
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1;
      rand_in();
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", ov1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", ov1, 0);
    chk("arst_valid_w", ov2, 0);
    chk("arst_re", ore1, 0);
    chk("arst_im", oim1, 0);
    chk("arst_ovf", of1, 0);
    chk("arst_sticky", st1, 0);
    q1.delete();
    q2.delete();
    m_st1 = 1'b0;
    m_st2 = 1'b0;
    p_hold = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    send_one("post_rst", 100, -50, 128, 0, 1'b0, 50, -25, 1'b0, 50, -25, 1'b0);

    // Randomized traffic with random backpressure and clears
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom % 4 != 0);
      out_ready = ($urandom % 4 != 0);
      ovf_clr   = ($urandom % 16 == 0);
      rand_in();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    for (int t = 0; t < 20 && q1.size() > 0; t++) tick();
    chk("drain_empty", q1.size(), 0);
    chk("drain_empty_w", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
